// File: rtl/bnn_conv_engine_if.sv
// bnn_conv_engine_if: job handshake plus input, output and weight SRAM ports of bnn_conv_engine.
// master = the engine, slave = the host and SRAM side.
interface bnn_conv_engine_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12
);
    logic              dut_run;
    logic              dut_busy;
    logic [ADDR_W-1:0] dut_sram_read_address;
    logic [DATA_W-1:0] sram_dut_read_data;
    logic [ADDR_W-1:0] dut_sram_write_address;
    logic [DATA_W-1:0] dut_sram_write_data;
    logic              dut_sram_write_enable;
    logic [ADDR_W-1:0] dut_wmem_read_address;
    logic [DATA_W-1:0] wmem_dut_read_data;

    modport master (
        input  dut_run,
        output dut_busy,
        output dut_sram_read_address,
        input  sram_dut_read_data,
        output dut_sram_write_address,
        output dut_sram_write_data,
        output dut_sram_write_enable,
        output dut_wmem_read_address,
        input  wmem_dut_read_data
    );

    modport slave (
        output dut_run,
        input  dut_busy,
        input  dut_sram_read_address,
        output sram_dut_read_data,
        input  dut_sram_write_address,
        input  dut_sram_write_data,
        input  dut_sram_write_enable,
        input  dut_wmem_read_address,
        output wmem_dut_read_data
    );
endinterface

// File: rtl/bnn_conv_engine.sv
// bnn_conv_engine: streams binary matrices from SRAM through one 3x3 XNOR-popcount kernel.
// Build option: define CONV_ZERO_PAD_EN for zero-padded "same" output (N rows of N bits per matrix).
module bnn_conv_engine #(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 12,
    parameter logic [ADDR_W-1:0] WMEM_ADDR = ADDR_W'(1),
    parameter int                THRESH    = 5,
    parameter logic [DATA_W-1:0] TERM_WORD = DATA_W'(16'h00FF)
) (
    input logic               clk,
    input logic               reset,
    bnn_conv_engine_if.master bus
);

    localparam int CW = 6;
`ifdef CONV_ZERO_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif
    localparam logic [CW-1:0] FILL_LAST = PAD ? CW'(0) : CW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WFETCH,
        S_HDR,
        S_FILL,
        S_OUT,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] wmem_addr;
    logic [8:0]        w_q;
    logic              w_pending;
    logic [CW-1:0]     n_q;
    logic [CW-1:0]     row_cnt;
    logic [DATA_W-1:0] win0;
    logic [DATA_W-1:0] win1;

    logic [CW-1:0]     hdr_n;
    logic              hdr_ok;
    logic [CW-1:0]     out_n;
    logic [CW-1:0]     out_last;
    logic [DATA_W-1:0] row_in;
    logic [2:0][DATA_W+1:0] ext;
    logic [8:0]        taps;
    logic [DATA_W-1:0] conv_bits;
    logic              write_en;
    logic              wmem_unused;

    function automatic logic [3:0] popcount9(input logic [8:0] v);
        logic [3:0] s;
        s = '0;
        for (int k = 0; k < 9; k++) s = s + {3'b000, v[k]};
        return s;
    endfunction

    assign wmem_unused = &{1'b0, bus.wmem_dut_read_data[DATA_W-1:9]};

    assign hdr_n    = {{(CW-5){1'b0}}, bus.sram_dut_read_data[4:0]};
    assign hdr_ok   = (bus.sram_dut_read_data != TERM_WORD) &&
                      (hdr_n >= CW'(3)) && (hdr_n <= CW'(DATA_W));
    assign out_n    = PAD ? n_q : n_q - CW'(2);
    assign out_last = PAD ? n_q : n_q - CW'(1);

    // Incoming row trimmed to N columns; the padded build's extra flush cycle sees an all-zero row.
    always_comb begin
        row_in = '0;
        for (int c = 0; c < DATA_W; c++)
            row_in[c] = bus.sram_dut_read_data[c] && (CW'(c) < n_q);
        if (PAD && row_cnt == n_q) row_in = '0;
    end

    // ext[i][c+j] is element (row i of the window, column c+j-offset); padding shifts in a zero column.
    always_comb begin
        ext[0]    = PAD ? {1'b0, win0, 1'b0}   : {2'b00, win0};
        ext[1]    = PAD ? {1'b0, win1, 1'b0}   : {2'b00, win1};
        ext[2]    = PAD ? {1'b0, row_in, 1'b0} : {2'b00, row_in};
        taps      = '0;
        conv_bits = '0;
        for (int c = 0; c < DATA_W; c++) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    taps[3*i+j] = ext[i][c+j];
            conv_bits[c] = (popcount9(~(taps ^ w_q)) >= 4'(THRESH)) && (CW'(c) < out_n);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt    = state;
        bus.dut_busy = 1'b0;
        write_en     = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.dut_run) state_nxt = S_WFETCH;
            end
            S_WFETCH: begin
                bus.dut_busy = 1'b1;
                state_nxt    = S_HDR;
            end
            S_HDR: begin
                bus.dut_busy = 1'b1;
                state_nxt    = hdr_ok ? S_FILL : S_DONE;
            end
            S_FILL: begin
                bus.dut_busy = 1'b1;
                if (row_cnt == FILL_LAST) state_nxt = S_OUT;
            end
            S_OUT: begin
                bus.dut_busy = 1'b1;
                write_en     = !reset;
                if (row_cnt == out_last) state_nxt = S_HDR;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        bus.dut_sram_write_enable  = write_en;
        bus.dut_sram_write_address = write_en ? wr_addr : '0;
        bus.dut_sram_write_data    = write_en ? conv_bits : '0;
    end

    assign bus.dut_sram_read_address = rd_addr;
    assign bus.dut_wmem_read_address = wmem_addr;

    // The read pointer advances every streaming cycle, so data always belongs to the previous address.
    // NOTE: registered state uses non-blocking assignments so all updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_addr   <= '0;
            wr_addr   <= '0;
            wmem_addr <= '0;
            w_q       <= '0;
            w_pending <= 1'b0;
            n_q       <= '0;
            row_cnt   <= '0;
            win0      <= '0;
            win1      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.dut_run) begin
                        rd_addr   <= '0;
                        wr_addr   <= '0;
                        wmem_addr <= WMEM_ADDR;
                    end
                end
                S_WFETCH: begin
                    rd_addr   <= rd_addr + ADDR_W'(1);
                    w_pending <= 1'b1;
                end
                S_HDR: begin
                    rd_addr <= rd_addr + ADDR_W'(1);
                    if (w_pending) begin
                        w_q       <= bus.wmem_dut_read_data[8:0];
                        w_pending <= 1'b0;
                    end
                    n_q     <= hdr_n;
                    row_cnt <= '0;
                    win0    <= '0;
                    win1    <= '0;
                end
                S_FILL: begin
                    rd_addr <= rd_addr + ADDR_W'(1);
                    row_cnt <= row_cnt + CW'(1);
                    win0    <= win1;
                    win1    <= row_in;
                end
                S_OUT: begin
                    // The padded build holds the pointer one cycle so the next header lands in HDR.
                    if (!(PAD && row_cnt == n_q - CW'(1))) rd_addr <= rd_addr + ADDR_W'(1);
                    row_cnt <= row_cnt + CW'(1);
                    win0    <= win1;
                    win1    <= row_in;
                    wr_addr <= wr_addr + ADDR_W'(1);
                end
                S_DONE: begin
                    rd_addr   <= '0;
                    wmem_addr <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/bnn_conv_engine.md
Name: bnn_conv_engine

Overview:
Parametrised successor of the team's fixed 3x3 binary-convolution accelerator. It walks a stream of square binary matrices in the input SRAM and applies one 3x3 XNOR-popcount kernel, fetched from the weight SRAM, to each matrix. Each output bit is thresholded and written row by row to the output SRAM. Matrix size, weight location, threshold and maximum row width are generalised, and optional zero padding is supported.

Parameters:
DATA_W, 16, SRAM word width and maximum matrix dimension N (N ≤ DATA_W).
ADDR_W, 12, width of all SRAM addresses.
WMEM_ADDR, 1, weight SRAM address holding the kernel.
THRESH, 5, output bit = 1 when the popcount of the 9 XNOR matches is ≥ THRESH (legal range 1..9).
TERM_WORD, 16'h00FF, header value that ends the stream.

Ports:
clk  in  1  single clock; all state changes on its rising edge.
reset  in  1  synchronous, active-high reset.
dut_run  in  1  start pulse; sampled only in IDLE.
dut_busy  out  1  high while a job is in progress.
dut_sram_read_address  out  ADDR_W  input SRAM read address.
sram_dut_read_data  in  DATA_W  input SRAM data; valid 1 cycle after its address is presented.
dut_sram_write_address  out  ADDR_W  output SRAM write address.
dut_sram_write_data  out  DATA_W  output SRAM write data.
dut_sram_write_enable  out  1  write strobe; one word is written per high cycle.
dut_wmem_read_address  out  ADDR_W  weight SRAM read address.
wmem_dut_read_data  in  DATA_W  weight data; valid 1 cycle after its address is presented.

Behaviour:
- Reset: synchronous, active-high (fixed), one clock. All outputs are 0 at reset; the FSM enters IDLE. Reset asserted mid-job aborts the job immediately: no further writes, and dut_busy=0 on the cycle after reset is sampled.
- Input layout: starts at address 0. Each matrix is one header word (N in bits [4:0], 3 ≤ N ≤ DATA_W) followed by N row words. Bit c of row r is element (r,c). The next header follows immediately. A header equal to TERM_WORD ends the job. A header with N<3 or N>DATA_W is treated as the terminator.
- Kernel: read once per job from WMEM_ADDR; bits [8:0] form w and upper bits are ignored.
- Window rule: out(r,c) = (Σ over i,j∈0..2 of XNOR(w[3i+j], in(r+i, c+j))) ≥ THRESH.
- Output: for each matrix, N-2 words are written. Each word holds N-2 valid bits in LSBs [N-3:0], and bits above are 0. Write addresses start at 0 per job and increment by 1 across matrices with no gaps. Each output row is written exactly once, in ascending row order.
- FSM:
  - IDLE: dut_run=1 → WFETCH. dut_busy rises on the cycle after dut_run is sampled.
  - WFETCH: latch w → HDR.
  - HDR: latch N. Terminator → DONE; otherwise → FILL.
  - FILL: load the first 3 rows into a 3-row shift window → OUT.
  - OUT: write one output row per new input row shifted in. After row N-1 is consumed, go to HDR at the next address.
  - DONE: dut_busy=0 → IDLE.
- Throughput: the input SRAM is read at most once per cycle. No extra stall cycles beyond 1-cycle read latency are allowed at matrix boundaries, beyond header decode (≤2 cycles).
- dut_busy falls no more than 2 cycles after the last write, or after the terminator header is read.
- dut_run while busy is ignored. dut_run asserted on the same cycle busy falls is also ignored; a new job needs dut_run in IDLE.
- dut_sram_write_enable is never high outside OUT, and never high while reset is asserted.

Optional Feature:
CONV_ZERO_PAD_EN: when defined, "same" padding applies. Out-of-range elements (r+i-1 or c+j-1 outside 0..N-1) read as 0, so the window is centred at (r,c). Each matrix produces N rows of N valid bits instead of N-2. When undefined, the block performs valid-only convolution as described above. Header parsing, addressing and handshake are identical in both builds.

Test Plan:
- N=4 all-ones rows (0x000F ×4), w=0x1FF, THRESH=5 → writes addr0=0x0003, addr1=0x0003; busy falls ≤2 cycles after the last write.
- Same input, w=0x000 → addr0=0x0000, addr1=0x0000 (popcount 0).
- Back-to-back N=16 all-ones then N=3 all-ones, then terminator, w=0x1FF → 14 writes of 0x3FFF at addresses 0..13, then 0x0001 at address 14, and no write at 15.
- Memory word 0 = 0x00FF → busy pulses high, zero writes; a second dut_run in IDLE is accepted and re-reads from address 0.
- Assert reset during the 3rd output write of an N=10 matrix → no writes after reset; all outputs 0 the next cycle; a fresh dut_run reruns the job correctly.
- CONV_ZERO_PAD_EN, N=3 all ones (0x0007), w=0x1FF → addr0=0x0002, addr1=0x0007, addr2=0x0002 (popcounts 4/6/4, 6/9/6, 4/6/4).
